// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 valid/ready stream multiplexer. Channel selection is either
// the external sel input (MODE 0) or round-robin arbitration (MODE 1).
module stream_mux_nto1 #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_src
);

  localparam int unsigned NU = N;

  logic [SW-1:0]    rr_ptr;
  logic             load;
  logic             gvalid;
  logic [SW-1:0]    gidx;
  logic [WIDTH-1:0] gdata;
  logic [N-1:0]     grant;

  assign load = !out_valid || out_ready;

  always_comb begin
    int unsigned ptr;
    int unsigned pos;
    int unsigned best;
    grant  = '0;
    gvalid = 1'b0;
    gidx   = '0;
    gdata  = '0;
    ptr    = 32'(rr_ptr);
    pos    = 0;
    best   = NU;
    for (int unsigned i = 0; i < NU; i++) begin
      if (MODE == 0) begin
        if (in_valid[i] && 32'(sel) == i) begin
          gvalid = 1'b1;
          gidx   = SW'(i);
          gdata  = in_data[i*WIDTH +: WIDTH];
        end
      end else if (in_valid[i]) begin
        // rank each valid channel by its distance after rr_ptr, modulo N
        pos = (i >= ptr) ? i - ptr : i + NU - ptr;
        if (pos < best) begin
          best   = pos;
          gvalid = 1'b1;
          gidx   = SW'(i);
          gdata  = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
    for (int unsigned i = 0; i < NU; i++) begin
      grant[i] = gvalid && (gidx == SW'(i));
    end
  end

  assign in_ready = (rst_n && load) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= gvalid;
      if (gvalid) begin
        out_data <= gdata;
        out_src  <= gidx;
        if (MODE == 1) begin
          rr_ptr <= (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: four instances (N=4/3, MODE 0/1) checked against
// a cycle-level reference model plus directed expectations.
module tb_stream_mux_nto1;

  localparam int W = 16;
  localparam int E1 [6] = '{0, 1, 2, 3, 0, 1};
  localparam int E2 [4] = '{0, 1, 2, 0};
  localparam int E3 [4] = '{1, 3, 1, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic out_ready;

  logic [3:0][4*W-1:0] dd;
  logic [3:0][3:0]     dv;
  logic [3:0][1:0]     ds;

  logic [3:0] ir0, ir1;
  logic [2:0] ir2, ir3;
  logic [W-1:0] od0, od1, od2, od3;
  logic ov0, ov1, ov2, ov3;
  logic [1:0] os0, os1, os2, os3;

  logic [3:0][3:0]   ir;
  logic [3:0][W-1:0] od;
  logic [3:0]        ov;
  logic [3:0][1:0]   os;

  assign ir = {{1'b0, ir3}, {1'b0, ir2}, ir1, ir0};
  assign od = {od3, od2, od1, od0};
  assign ov = {ov3, ov2, ov1, ov0};
  assign os = {os3, os2, os1, os0};

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic         m_v   [4];
  logic [W-1:0] m_d   [4];
  int           m_s   [4];
  int           m_ptr [4];

  always #5 clk = ~clk;

  stream_mux_nto1 #(.WIDTH(W), .N(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_data(dd[0]), .in_valid(dv[0]), .in_ready(ir0),
    .sel(ds[0]), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_src(os0));

  stream_mux_nto1 #(.WIDTH(W), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(dd[1]), .in_valid(dv[1]), .in_ready(ir1),
    .sel(ds[1]), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_src(os1));

  stream_mux_nto1 #(.WIDTH(W), .N(3), .MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(dd[2][3*W-1:0]), .in_valid(dv[2][2:0]), .in_ready(ir2),
    .sel(ds[2]), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_src(os2));

  stream_mux_nto1 #(.WIDTH(W), .N(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(dd[3][3*W-1:0]), .in_valid(dv[3][2:0]), .in_ready(ir3),
    .sel(ds[3]), .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .out_src(os3));

  function automatic int nch(input int k);
    return (k < 2) ? 4 : 3;
  endfunction

  function automatic bit is_rr(input int k);
    return (k == 1 || k == 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic do_cycle();
    int g [4];
    logic ld [4];
    logic [3:0] exp_ir;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = nch(k);
      if (!rst_n) begin
        m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_ptr[k] = 0;
      end
      chk($sformatf("ov%0d", k), 64'(ov[k]), 64'(m_v[k]));
      chk($sformatf("od%0d", k), 64'(od[k]), 64'(m_d[k]));
      chk($sformatf("os%0d", k), 64'(os[k]), 64'(m_s[k]));
      g[k] = -1;
      ld[k] = !m_v[k] || out_ready;
      if (is_rr(k)) begin
        for (int o = 0; o < n; o++) begin
          if (g[k] < 0 && dv[k][(m_ptr[k] + o) % n]) g[k] = (m_ptr[k] + o) % n;
        end
      end else if (int'(ds[k]) < n && dv[k][ds[k]]) begin
        g[k] = int'(ds[k]);
      end
      exp_ir = (rst_n && ld[k] && g[k] >= 0) ? (4'b0001 << g[k]) : 4'b0000;
      chk($sformatf("ir%0d", k), 64'(ir[k]), 64'(exp_ir));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (rst_n && ld[k]) begin
        if (g[k] >= 0) begin
          m_v[k] = 1'b1;
          m_d[k] = dd[k][g[k]*W +: W];
          m_s[k] = g[k];
          if (is_rr(k)) m_ptr[k] = (g[k] + 1) % nch(k);
        end else begin
          m_v[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dd[k] = {$urandom, $urandom};
      dv[k] = '1;
      ds[k] = '0;
      m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_ptr[k] = 0;
    end
    dd[0] = 64'hDDDD_CCCC_BBBB_AAAA;
    ds[0] = 2'd2;
    #2 rst_n = 1'b0;

    repeat (3) do_cycle();
    chk("rst_ov", 64'(ov), 64'h0);
    chk("rst_ir", 64'(ir), 64'h0);

    rst_n = 1'b1;
    #1;
    chk("post_rst_od0", 64'(od[0]), 64'h0);
    chk("sel2_ir0", 64'(ir[0]), 64'b0100);

    for (int i = 0; i < 6; i++) begin
      if (i == 1) ds[0] = 2'd1;
      do_cycle();
      chk($sformatf("rr4_seq%0d", i), 64'(os[1]), 64'(E1[i]));
      if (i < 4) chk($sformatf("rr3_seq%0d", i), 64'(os[2]), 64'(E2[i]));
      if (i == 0) begin
        chk("sel2_od0", 64'(od[0]), 64'hCCCC);
        chk("sel2_os0", 64'(os[0]), 64'd2);
      end
      if (i == 1) begin
        chk("sel1_od0", 64'(od[0]), 64'hBBBB);
        chk("sel1_os0", 64'(os[0]), 64'd1);
        chk("sel1_ov0", 64'(ov[0]), 64'd1);
      end
    end

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_ir0_%0d", i), 64'(ir[0]), 64'h0);
      do_cycle();
      chk($sformatf("bp_od0_%0d", i), 64'(od[0]), 64'hBBBB);
      chk($sformatf("bp_os0_%0d", i), 64'(os[0]), 64'd1);
      chk($sformatf("bp_ov0_%0d", i), 64'(ov[0]), 64'd1);
    end

    out_ready = 1'b1;
    ds[0] = 2'd3;
    dd[0][63:48] = 16'h1234;
    do_cycle();
    chk("drain_od0_a", 64'(od[0]), 64'h1234);
    chk("drain_os0_a", 64'(os[0]), 64'd3);
    chk("drain_rr4_a", 64'(os[1]), 64'd2);
    dd[0][63:48] = 16'h5678;
    do_cycle();
    chk("drain_od0_b", 64'(od[0]), 64'h5678);
    chk("drain_rr4_b", 64'(os[1]), 64'd3);

    dv[1] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      chk($sformatf("rr4_13_%0d", i), 64'(os[1]), 64'(E3[i]));
    end
    dv[1] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      chk($sformatf("rr4_1_%0d", i), 64'(os[1]), 64'd1);
    end

    out_ready = 1'b0;
    ds[3] = 2'd3;
    do_cycle();
    chk("sel3_hold_ov3", 64'(ov[3]), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("sel3_ir3", 64'(ir[3]), 64'h0);
    do_cycle();
    chk("sel3_drain_ov3", 64'(ov[3]), 64'd0);

    rst_n = 1'b0;
    #1;
    chk("async_rst_ov", 64'(ov), 64'h0);
    chk("async_rst_od0", 64'(od[0]), 64'h0);
    repeat (2) do_cycle();
    rst_n = 1'b1;
    do_cycle();
    chk("post_rst_ov0", 64'(ov[0]), 64'd1);
    chk("post_rst_od0_b", 64'(od[0]), 64'h5678);

    repeat (300) begin
      for (int k = 0; k < 4; k++) begin
        dd[k] = {$urandom, $urandom};
        dv[k] = 4'($urandom);
        ds[k] = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end
    do_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
